// File: rtl/addr_sreg_ctr.sv
// ---------------------------------------------------------------------------
// addr_sreg_ctr
//
// Serial-load address register with auto-step counter and serial readback.
// The MCU shifts a DWIDTH-bit address into a shadow register (MSB first)
// while en_n is low. When en_n rises, the shadow is committed to the live
// address only if exactly DWIDTH bits were shifted; otherwise the sticky
// frame_err flag is set. Between frames, each clock with counter_n low steps
// the live address up or down by STEP, wrapping or saturating.
// The previous live address is shifted out on sout during each load.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in         serial data in, sampled while en_n = 0
//   en_n       active-low shift enable / frame window
//   counter_n  active-low step strobe, one step per clk while low
//   dir        step direction: 0 = up (+STEP), 1 = down (-STEP)
//   out        live address
//   sout       serial readback (MSB of readback register)
//   frame_err  sticky: last frame had a wrong bit count
//   busy       1 while a frame is in progress (registered en_n inverted)
//   debug      {en_n, frame_err, out[5:0]}
// ---------------------------------------------------------------------------
module addr_sreg_ctr #(
    parameter int DWIDTH = 21,
    parameter int STEP   = 1,
    parameter int WRAP   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in,
    input  logic              en_n,
    input  logic              counter_n,
    input  logic              dir,
    output logic [DWIDTH-1:0] out,
    output logic              sout,
    output logic              frame_err,
    output logic              busy,
    output logic [7:0]        debug
);

    // Counter holds 0..DWIDTH+1; DWIDTH+1 marks an overrun and sticks there.
    localparam int CW = $clog2(DWIDTH + 2);
    localparam logic [CW-1:0]     CNT_FULL = CW'(DWIDTH);
    localparam logic [CW-1:0]     CNT_SAT  = CW'(DWIDTH + 1);
    localparam logic [DWIDTH-1:0] STEP_V   = DWIDTH'(STEP);

    logic [DWIDTH-1:0] shadow_reg, shadow_next;
    logic [DWIDTH-1:0] out_reg,    out_next;
    logic [DWIDTH-1:0] rb_reg,     rb_next;
    logic [CW-1:0]     bitcnt_reg, bitcnt_next;
    logic              frame_err_reg, frame_err_next;
    logic              en_q_reg;

    logic              frame_start;
    logic              frame_end;
    logic              idle;
    logic [DWIDTH:0]   sum_up;
    logic [DWIDTH:0]   diff_dn;
    logic [DWIDTH-1:0] stepped;

    assign frame_start = ~en_n & en_q_reg;
    assign frame_end   = en_n & ~en_q_reg;
    assign idle        = en_n & en_q_reg;

    // One extra bit on each side exposes carry (up) or borrow (down).
    assign sum_up  = {1'b0, out_reg} + {1'b0, STEP_V};
    assign diff_dn = {1'b0, out_reg} - {1'b0, STEP_V};

    always_comb begin
        stepped = out_reg;
        if (dir) begin
            if (diff_dn[DWIDTH] && (WRAP == 0))
                stepped = '0;
            else
                stepped = diff_dn[DWIDTH-1:0];
        end else begin
            if (sum_up[DWIDTH] && (WRAP == 0))
                stepped = '1;
            else
                stepped = sum_up[DWIDTH-1:0];
        end
    end

    // Commit on frame end takes priority; stepping only happens when idle.
    always_comb begin
        out_next = out_reg;
        if (frame_end) begin
            if (bitcnt_reg == CNT_FULL)
                out_next = shadow_reg;
        end else if (idle && !counter_n) begin
            out_next = stepped;
        end
    end

    always_comb begin
        shadow_next    = shadow_reg;
        bitcnt_next    = bitcnt_reg;
        frame_err_next = frame_err_reg;
        if (!en_n) begin
            shadow_next = {shadow_reg[DWIDTH-2:0], in};
            if (frame_start) begin
                bitcnt_next    = CW'(1);
                frame_err_next = 1'b0;
            end else if (bitcnt_reg != CNT_SAT) begin
                bitcnt_next = bitcnt_reg + CW'(1);
            end
        end else if (frame_end) begin
            bitcnt_next = '0;
            if (bitcnt_reg != CNT_FULL)
                frame_err_next = 1'b1;
        end
    end

    // Readback tracks the address the register is about to hold, so the
    // first shift edge already sees its MSB on sout.
    assign rb_next = en_n ? out_next : {rb_reg[DWIDTH-2:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_reg    <= '0;
            out_reg       <= '0;
            rb_reg        <= '0;
            bitcnt_reg    <= '0;
            frame_err_reg <= 1'b0;
            en_q_reg      <= 1'b1;
        end else begin
            shadow_reg    <= shadow_next;
            out_reg       <= out_next;
            rb_reg        <= rb_next;
            bitcnt_reg    <= bitcnt_next;
            frame_err_reg <= frame_err_next;
            en_q_reg      <= en_n;
        end
    end

    assign out       = out_reg;
    assign sout      = rb_reg[DWIDTH-1];
    assign frame_err = frame_err_reg;
    assign busy      = ~en_q_reg;

    // Narrow addresses are zero-extended into the debug byte.
    generate
        if (DWIDTH >= 6) begin : g_dbg_wide
            assign debug = {en_n, frame_err_reg, out_reg[5:0]};
        end else begin : g_dbg_narrow
            assign debug = {en_n, frame_err_reg, {(6-DWIDTH){1'b0}}, out_reg};
        end
    endgenerate

endmodule

// File: tb/tb_addr_sreg_ctr.sv
// ---------------------------------------------------------------------------
// tb_addr_sreg_ctr
//
// Directed bench for addr_sreg_ctr. Four instances share the same stimulus:
//   a: STEP=1 WRAP=1, b: STEP=1 WRAP=0, c: STEP=4 WRAP=0, d: STEP=4 WRAP=1.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_addr_sreg_ctr;

    logic clk;
    logic rst_n;
    logic in;
    logic en_n;
    logic counter_n;
    logic dir;

    logic [20:0] out_a, out_b, out_c, out_d;
    logic        sout_a, sout_b, sout_c, sout_d;
    logic        ferr_a, ferr_b, ferr_c, ferr_d;
    logic        busy_a, busy_b, busy_c, busy_d;
    logic [7:0]  dbg_a, dbg_b, dbg_c, dbg_d;

    int vectors;
    int miscompares;

    addr_sreg_ctr #(.DWIDTH(21), .STEP(1), .WRAP(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in(in), .en_n(en_n), .counter_n(counter_n),
        .dir(dir), .out(out_a), .sout(sout_a), .frame_err(ferr_a),
        .busy(busy_a), .debug(dbg_a));

    addr_sreg_ctr #(.DWIDTH(21), .STEP(1), .WRAP(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in(in), .en_n(en_n), .counter_n(counter_n),
        .dir(dir), .out(out_b), .sout(sout_b), .frame_err(ferr_b),
        .busy(busy_b), .debug(dbg_b));

    addr_sreg_ctr #(.DWIDTH(21), .STEP(4), .WRAP(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .in(in), .en_n(en_n), .counter_n(counter_n),
        .dir(dir), .out(out_c), .sout(sout_c), .frame_err(ferr_c),
        .busy(busy_c), .debug(dbg_c));

    addr_sreg_ctr #(.DWIDTH(21), .STEP(4), .WRAP(1)) dut_d (
        .clk(clk), .rst_n(rst_n), .in(in), .en_n(en_n), .counter_n(counter_n),
        .dir(dir), .out(out_d), .sout(sout_d), .frame_err(ferr_d),
        .busy(busy_d), .debug(dbg_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shift the low nbits of value MSB first, then raise en_n and wait for
    // the commit edge. Returns on the falling edge after the commit.
    task automatic load(input logic [31:0] value, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            @(negedge clk);
            en_n = 1'b0;
            in   = value[i];
        end
        @(negedge clk);
        en_n = 1'b1;
        in   = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en_n = 1'b1; counter_n = 1'b1; dir = 1'b0; in = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (out_a !== 21'h0) begin miscompares++;
            $display("FAIL reset_out got %h want %h", out_a, 21'h0); end
        vectors++;
        if (ferr_a !== 1'b0) begin miscompares++;
            $display("FAIL reset_ferr got %b want 0", ferr_a); end
        vectors++;
        if (busy_a !== 1'b0) begin miscompares++;
            $display("FAIL reset_busy got %b want 0", busy_a); end
        vectors++;
        if (sout_a !== 1'b0) begin miscompares++;
            $display("FAIL reset_sout got %b want 0", sout_a); end
        vectors++;
        if (dbg_a !== 8'h80) begin miscompares++;
            $display("FAIL reset_debug got %h want 80", dbg_a); end
        rst_n = 1'b1;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_load();
        logic [20:0] v;
        v = 21'h12345;
        for (int i = 20; i >= 0; i--) begin
            @(negedge clk);
            if (i != 20) begin
                vectors++;
                if (busy_a !== 1'b1) begin miscompares++;
                    $display("FAIL load_busy bit %0d got %b want 1", i, busy_a); end
            end
            en_n = 1'b0;
            in   = v[i];
        end
        @(negedge clk);
        vectors++;
        if (busy_a !== 1'b1) begin miscompares++;
            $display("FAIL load_busy_last got %b want 1", busy_a); end
        vectors++;
        if (out_a !== 21'h0) begin miscompares++;
            $display("FAIL load_out_before_commit got %h want 0", out_a); end
        en_n = 1'b1; in = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_a !== 21'h12345) begin miscompares++;
            $display("FAIL load_out got %h want 12345", out_a); end
        vectors++;
        if (ferr_a !== 1'b0) begin miscompares++;
            $display("FAIL load_ferr got %b want 0", ferr_a); end
        vectors++;
        if (busy_a !== 1'b0) begin miscompares++;
            $display("FAIL load_busy_after got %b want 0", busy_a); end
        vectors++;
        if (dbg_a !== 8'h85) begin miscompares++;
            $display("FAIL load_debug got %h want 85", dbg_a); end
        $display("test_load done out=%h", out_a);
    endtask

    task automatic test_step_up();
        logic [20:0] exp_a [3];
        logic [20:0] exp_b [3];
        exp_a[0] = 21'h1FFFFF; exp_a[1] = 21'h000000; exp_a[2] = 21'h000001;
        exp_b[0] = 21'h1FFFFF; exp_b[1] = 21'h1FFFFF; exp_b[2] = 21'h1FFFFF;
        load(32'h1FFFFE, 21);
        dir = 1'b0;
        counter_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (out_a !== exp_a[k]) begin miscompares++;
                $display("FAIL step_up_wrap %0d got %h want %h", k, out_a, exp_a[k]); end
            vectors++;
            if (out_b !== exp_b[k]) begin miscompares++;
                $display("FAIL step_up_sat %0d got %h want %h", k, out_b, exp_b[k]); end
        end
        counter_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_a !== 21'h000001) begin miscompares++;
            $display("FAIL step_hold got %h want 000001", out_a); end
        $display("test_step_up done a=%h b=%h", out_a, out_b);
    endtask

    task automatic test_step_down();
        load(32'h000002, 21);
        dir = 1'b1;
        counter_n = 1'b0;
        @(negedge clk);
        counter_n = 1'b1;
        vectors++;
        if (out_c !== 21'h000000) begin miscompares++;
            $display("FAIL step_dn_sat4 got %h want 000000", out_c); end
        vectors++;
        if (out_d !== 21'h1FFFFE) begin miscompares++;
            $display("FAIL step_dn_wrap4 got %h want 1ffffe", out_d); end
        vectors++;
        if (out_a !== 21'h000001) begin miscompares++;
            $display("FAIL step_dn_1 got %h want 000001", out_a); end
        dir = 1'b0;
        $display("test_step_down done c=%h d=%h", out_c, out_d);
    endtask

    task automatic test_frame_err();
        load(32'h0ABCD, 20);
        vectors++;
        if (out_a !== 21'h000001) begin miscompares++;
            $display("FAIL short_out got %h want 000001", out_a); end
        vectors++;
        if (ferr_a !== 1'b1) begin miscompares++;
            $display("FAIL short_ferr got %b want 1", ferr_a); end
        load(32'h2ABCDE, 22);
        vectors++;
        if (out_a !== 21'h000001) begin miscompares++;
            $display("FAIL long_out got %h want 000001", out_a); end
        vectors++;
        if (ferr_a !== 1'b1) begin miscompares++;
            $display("FAIL long_ferr got %b want 1", ferr_a); end
        load(32'h0000AA, 21);
        vectors++;
        if (out_a !== 21'h0000AA) begin miscompares++;
            $display("FAIL good_out got %h want 0000aa", out_a); end
        vectors++;
        if (ferr_a !== 1'b0) begin miscompares++;
            $display("FAIL good_ferr got %b want 0", ferr_a); end
        load(32'h1, 1);
        vectors++;
        if (out_a !== 21'h0000AA) begin miscompares++;
            $display("FAIL onebit_out got %h want 0000aa", out_a); end
        vectors++;
        if (ferr_a !== 1'b1) begin miscompares++;
            $display("FAIL onebit_ferr got %b want 1", ferr_a); end
        $display("test_frame_err done out=%h ferr=%b", out_a, ferr_a);
    endtask

    task automatic test_readback();
        logic [20:0] nv;
        logic [20:0] got;
        load(32'h155555, 21);
        nv  = 21'h0F0F0;
        got = '0;
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            got = {got[19:0], sout_a};
            en_n = 1'b0;
            counter_n = 1'b0;
            in = nv[20-k];
        end
        @(negedge clk);
        vectors++;
        if (out_a !== 21'h155555) begin miscompares++;
            $display("FAIL rb_out_hold got %h want 155555", out_a); end
        en_n = 1'b1; in = 1'b0;
        @(negedge clk);
        counter_n = 1'b1;
        vectors++;
        if (out_a !== 21'h0F0F0) begin miscompares++;
            $display("FAIL rb_commit_nostep got %h want 0f0f0", out_a); end
        vectors++;
        if (got !== 21'h155555) begin miscompares++;
            $display("FAIL rb_bits got %h want 155555", got); end
        $display("test_readback done rb=%h out=%h", got, out_a);
    endtask

    task automatic test_reset_mid_frame();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            en_n = 1'b0;
            in = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b0; en_n = 1'b1; in = 1'b0;
        #1;
        vectors++;
        if (out_a !== 21'h0) begin miscompares++;
            $display("FAIL midrst_out_async got %h want 0", out_a); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (out_a !== 21'h0) begin miscompares++;
            $display("FAIL midrst_out got %h want 0", out_a); end
        vectors++;
        if (ferr_a !== 1'b0) begin miscompares++;
            $display("FAIL midrst_ferr got %b want 0", ferr_a); end
        vectors++;
        if (busy_a !== 1'b0) begin miscompares++;
            $display("FAIL midrst_busy got %b want 0", busy_a); end
        $display("test_reset_mid_frame done out=%h", out_a);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_load();
        test_step_up();
        test_step_down();
        test_frame_err();
        test_readback();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/addr_sreg_ctr.md
Name: addr_sreg_ctr

Overview:
- Parametrised successor to the serial-load address register in the CPLD.
- The MCU shifts a DWIDTH-bit address into a shadow register, MSB first. The address is committed to the live output only if exactly DWIDTH bits were shifted.
- The live address then auto-steps up or down by STEP on each counter strobe, with wrap or saturate.
- The previous live address is shifted back out serially during each load for MCU readback.

Parameters:
- DWIDTH, 21, address width in bits (>=2).
- STEP, 1, increment/decrement amount per counter strobe (1..2^DWIDTH-1).
- WRAP, 1, 1 = modulo 2^DWIDTH stepping; 0 = saturate at all-ones (up) or zero (down).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in  in  1  serial data in, sampled while en_n=0
- en_n  in  1  active-low shift enable / frame window
- counter_n  in  1  active-low step strobe, one step per clk while low
- dir  in  1  step direction: 0 = up (+STEP), 1 = down (-STEP)
- out  out  DWIDTH  live address
- sout  out  1  serial readback, = rb[DWIDTH-1]
- frame_err  out  1  sticky: last frame had wrong bit count
- busy  out  1  1 while a frame is in progress (registered en_n inverted)
- debug  out  8  {en_n, frame_err, out[5:0]}

Behaviour:
- Reset (async, rst_n=0): shadow, out, rb and bit counter = 0; frame_err = 0; en_q = 1; busy = 0; sout = 0.
- en_q: registered copy of en_n. Frame start = en_n=0 & en_q=1; frame end = en_n=1 & en_q=0.
- Shift (en_n=0, each clk):
  - shadow <= {shadow[DWIDTH-2:0], in}.
  - rb <= {rb[DWIDTH-2:0], 0}.
  - bitcnt increments, saturating at DWIDTH+1 (width clog2(DWIDTH+2)).
  - counter_n is ignored; out holds.
- Frame start cycle: bitcnt restarts at 1 (this cycle's bit counted); frame_err is cleared.
- Frame end cycle (first clk with en_n=1 after a low period):
  - If bitcnt == DWIDTH: out <= shadow; frame_err stays 0.
  - Otherwise: out unchanged; frame_err <= 1.
  - counter_n is ignored this cycle; commit has priority and no step is applied.
  - bitcnt <= 0.
- Idle step (en_n=1, en_q=1, counter_n=0):
  - dir=0: out <= out+STEP.
  - dir=1: out <= out-STEP.
  - WRAP=1: arithmetic modulo 2^DWIDTH.
  - WRAP=0: clamp to 2^DWIDTH-1 (up) or 0 (down) when the true result would overflow or underflow.
- Idle without strobe: out holds.
- Readback: in every cycle with en_n=1, rb <= the value out takes at that edge.
  - sout therefore presents the MSB of the current address before the first shift edge.
  - Each shift edge exposes the next lower bit; zeros follow after DWIDTH bits.
- Zero-length pulse is impossible (en_n is sampled); a 1-cycle en_n low = 1-bit frame, giving frame_err=1.
- Overrun (more than DWIDTH bits): bitcnt saturates at DWIDTH+1, so no commit and frame_err=1.
- Reset mid-frame: all state returns to reset values immediately; the partial frame is discarded; no commit after release.
- No combinational path from inputs to outputs except debug[7] (en_n).

Test Plan:
1. Reset, then shift 21 bits of 0x12345 MSB first, raise en_n → out=0x12345 on the cycle after en_n rises; frame_err=0; busy=1 during the 21 shift cycles.
2. Load 0x1FFFFE, dir=0, hold counter_n low 3 clks, WRAP=1 → out = 0x1FFFFF, 0x000000, 0x000001. Same stimulus with WRAP=0 → 0x1FFFFF, 0x1FFFFF, 0x1FFFFF.
3. Load 0x000002, dir=1, STEP=4, WRAP=0, counter_n low 1 clk → out=0x000000; WRAP=1 → out=0x1FFFFE.
4. Frame with 20 bits, then a frame with 22 bits → out keeps its prior value, frame_err=1 after each. A following correct 21-bit frame of 0x0000AA → out=0x0000AA, frame_err=0.
5. out=0x155555, start a frame and capture sout on each shift edge → the 21 collected bits equal 0x155555. counter_n held low during the frame and on the commit cycle → no step applied.
6. Assert rst_n=0 after 10 shift bits, release, then idle → out=0, frame_err=0, busy=0, no commit.
